// File: rtl/cpu_ctrl_fsm.sv
// Instruction register, field decoder and multi-cycle Moore control FSM that
// sequences regfile reads/writes and datapath load strobes for each instruction.
module cpu_ctrl_fsm #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s,
    input  logic              load,
    input  logic [DATA_W-1:0] in,
    output logic              w,
    output logic [REG_W-1:0]  readnum,
    output logic [REG_W-1:0]  writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic              vsel,
    output logic [1:0]        op_alu,
    output logic [1:0]        shift,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5
);

    localparam logic [2:0] ST_WAIT      = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_GET_A     = 3'd2;
    localparam logic [2:0] ST_GET_B     = 3'd3;
    localparam logic [2:0] ST_COMPUTE   = 3'd4;
    localparam logic [2:0] ST_WRITE_REG = 3'd5;
    localparam logic [2:0] ST_WRITE_IMM = 3'd6;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    logic [DATA_W-1:0] ir;
    logic [2:0]        state;
    logic [2:0]        state_nxt;

    logic [2:0]       opcode;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rm;

    assign opcode = ir[15:13];
    assign op_alu = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];
    assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
    assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
    assign shift  = bsel ? 2'b00 : ir[4:3];

    // NOTE: state and IR use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir    <= '0;
            state <= ST_WAIT;
        end else begin
            if (load) ir <= in;
            state <= state_nxt;
        end
    end

    // Decode always reads the live IR, so a reload mid-instruction steers the
    // remaining steps of the instruction already in flight.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            ST_WAIT:   if (s) state_nxt = ST_DECODE;
            ST_DECODE: begin
                state_nxt = ST_WAIT;
                if (opcode == OPC_MOV && op_alu == 2'b10)      state_nxt = ST_WRITE_IMM;
                else if (opcode == OPC_MOV && op_alu == 2'b00) state_nxt = ST_GET_B;
                else if (opcode == OPC_ALU && op_alu == 2'b11) state_nxt = ST_GET_B;
                else if (opcode == OPC_ALU)                    state_nxt = ST_GET_A;
            end
            ST_GET_A:     state_nxt = ST_GET_B;
            ST_GET_B:     state_nxt = ST_COMPUTE;
            ST_COMPUTE:   state_nxt = (op_alu == 2'b01 && opcode == OPC_ALU) ? ST_WAIT
                                                                              : ST_WRITE_REG;
            ST_WRITE_REG: state_nxt = ST_WAIT;
            ST_WRITE_IMM: state_nxt = ST_WAIT;
            default:      state_nxt = ST_WAIT;
        endcase
    end

    always_comb begin
        w        = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 1'b0;
        case (state)
            ST_WAIT:  w = 1'b1;
            ST_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            ST_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            ST_COMPUTE: begin
                loadc = 1'b1;
                // MOV reg and MVN pass only B through the ALU, so A is zeroed.
                asel  = (opcode == OPC_MOV) || (op_alu == 2'b11);
                loads = (opcode == OPC_ALU) && (op_alu == 2'b01);
            end
            ST_WRITE_REG: begin
                writenum = rd;
                write    = 1'b1;
            end
            ST_WRITE_IMM: begin
                writenum = rn;
                vsel     = 1'b1;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed self-checking bench for cpu_ctrl_fsm: per-state strobes, decode
// fields, latencies, undefined opcode, live-IR reload and async reset abort.
module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, vsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  op_alu, shift;
    logic [15:0] sximm8, sximm5;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_ctrl_fsm dut (
        .clk(clk), .reset_n(reset_n), .s(s), .load(load), .in(in),
        .w(w), .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .op_alu(op_alu),
        .shift(shift), .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    // Strobe bundle: {w, write, loada, loadb, loadc, loads, asel, bsel, vsel}
    logic [8:0] strobes;
    assign strobes = {w, write, loada, loadb, loadc, loads, asel, bsel, vsel};

    localparam logic [8:0] S_WAIT = 9'b1_0000_0000;
    localparam logic [8:0] S_NONE = 9'b0_0000_0000;
    localparam logic [8:0] S_WIMM = 9'b0_1000_0001;
    localparam logic [8:0] S_WREG = 9'b0_1000_0000;
    localparam logic [8:0] S_GETA = 9'b0_0100_0000;
    localparam logic [8:0] S_GETB = 9'b0_0010_0000;
    localparam logic [8:0] S_CADD = 9'b0_0001_0000;
    localparam logic [8:0] S_CCMP = 9'b0_0001_1000;
    localparam logic [8:0] S_CMVN = 9'b0_0001_0100;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [15:0] instr);
        in   = instr;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic start();
        s = 1'b1;
        tick();
        s = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        s = 1'b0; load = 1'b0; in = 16'h0000;
        #1;
        chk("reset_strobes", {7'd0, strobes}, {7'd0, S_WAIT});
        tick(); tick();
        chk("reset_readnum", {13'd0, readnum}, 16'd0);
        chk("reset_writenum", {13'd0, writenum}, 16'd0);
        chk("reset_sximm8", sximm8, 16'h0000);
        reset_n = 1'b1;
        tick();
        chk("idle_after_release", {7'd0, strobes}, {7'd0, S_WAIT});

        // MOV R0,#7
        load_ir(16'hD007);
        chk("mov7_sximm8", sximm8, 16'h0007);
        chk("mov7_loaded_wait", {7'd0, strobes}, {7'd0, S_WAIT});
        start();
        chk("mov7_decode", {7'd0, strobes}, {7'd0, S_NONE});
        tick();
        chk("mov7_wimm", {7'd0, strobes}, {7'd0, S_WIMM});
        chk("mov7_writenum", {13'd0, writenum}, 16'd0);
        tick();
        chk("mov7_back_wait", {7'd0, strobes}, {7'd0, S_WAIT});

        // MOV R1,#-2
        load_ir(16'hD1FE);
        chk("movm2_sximm8", sximm8, 16'hFFFE);
        chk("movm2_sximm5", sximm5, 16'hFFFE);
        start();
        tick();
        chk("movm2_wimm", {7'd0, strobes}, {7'd0, S_WIMM});
        chk("movm2_writenum", {13'd0, writenum}, 16'd1);
        tick();
        chk("movm2_single_pulse", {7'd0, strobes}, {7'd0, S_WAIT});

        // ADD R2,R1,R0,LSL#1
        load_ir(16'hA148);
        start();
        chk("add_decode", {7'd0, strobes}, {7'd0, S_NONE});
        tick();
        chk("add_geta", {7'd0, strobes}, {7'd0, S_GETA});
        chk("add_geta_readnum", {13'd0, readnum}, 16'd1);
        tick();
        chk("add_getb", {7'd0, strobes}, {7'd0, S_GETB});
        chk("add_getb_readnum", {13'd0, readnum}, 16'd0);
        tick();
        chk("add_compute", {7'd0, strobes}, {7'd0, S_CADD});
        chk("add_shift", {14'd0, shift}, 16'd1);
        chk("add_op_alu", {14'd0, op_alu}, 16'd0);
        tick();
        chk("add_wreg", {7'd0, strobes}, {7'd0, S_WREG});
        chk("add_writenum", {13'd0, writenum}, 16'd2);
        tick();
        chk("add_back_wait", {7'd0, strobes}, {7'd0, S_WAIT});

        // CMP R1,R0
        load_ir(16'hA900);
        start();
        tick();
        chk("cmp_geta", {7'd0, strobes}, {7'd0, S_GETA});
        tick();
        chk("cmp_getb", {7'd0, strobes}, {7'd0, S_GETB});
        tick();
        chk("cmp_compute", {7'd0, strobes}, {7'd0, S_CCMP});
        chk("cmp_op_alu", {14'd0, op_alu}, 16'd1);
        tick();
        chk("cmp_back_wait_no_write", {7'd0, strobes}, {7'd0, S_WAIT});

        // MVN R3,R2
        load_ir(16'hB862);
        start();
        tick();
        chk("mvn_getb", {7'd0, strobes}, {7'd0, S_GETB});
        chk("mvn_getb_readnum", {13'd0, readnum}, 16'd2);
        tick();
        chk("mvn_compute_asel", {7'd0, strobes}, {7'd0, S_CMVN});
        tick();
        chk("mvn_wreg", {7'd0, strobes}, {7'd0, S_WREG});
        chk("mvn_writenum", {13'd0, writenum}, 16'd3);
        tick();
        chk("mvn_back_wait", {7'd0, strobes}, {7'd0, S_WAIT});

        // Undefined opcode 111
        load_ir(16'hE000);
        start();
        chk("undef_decode", {7'd0, strobes}, {7'd0, S_NONE});
        tick();
        chk("undef_back_wait", {7'd0, strobes}, {7'd0, S_WAIT});

        // ADD with s pulses while busy and an IR reload changing Rd to 3
        load_ir(16'hA148);
        start();
        tick();
        chk("live_geta", {7'd0, strobes}, {7'd0, S_GETA});
        s = 1'b1; load = 1'b1; in = 16'hA160;
        tick();
        s = 1'b0; load = 1'b0;
        chk("live_getb", {7'd0, strobes}, {7'd0, S_GETB});
        s = 1'b1;
        tick();
        s = 1'b0;
        chk("live_compute", {7'd0, strobes}, {7'd0, S_CADD});
        tick();
        chk("live_wreg", {7'd0, strobes}, {7'd0, S_WREG});
        chk("live_writenum_new_rd", {13'd0, writenum}, 16'd3);
        tick();
        chk("live_back_wait", {7'd0, strobes}, {7'd0, S_WAIT});
        tick();
        chk("live_stays_wait", {7'd0, strobes}, {7'd0, S_WAIT});

        // Async reset in GET_B
        load_ir(16'hA148);
        start();
        tick();
        tick();
        chk("rst_pre_getb", {7'd0, strobes}, {7'd0, S_GETB});
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_strobes", {7'd0, strobes}, {7'd0, S_WAIT});
        chk("rst_async_readnum", {13'd0, readnum}, 16'd0);
        chk("rst_async_ir_cleared", sximm8, 16'h0000);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_no_partial_write", {7'd0, strobes}, {7'd0, S_WAIT});
        tick();
        chk("rst_still_idle", {7'd0, strobes}, {7'd0, S_WAIT});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
